// File: rtl/mod12_counter_sequencer_pkg.sv
// Shared types and constants for the mod-12 counter sequencer.
package mod12_seq_pkg;

    typedef enum logic [1:0] {
        OP_LOAD      = 2'd0,
        OP_STEP_UP   = 2'd1,
        OP_STEP_DOWN = 2'd2,
        OP_READ      = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_STEP = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam logic [3:0] MOD_MAX = 4'd11;

    // Wrap count reported to the requester saturates at 3.
    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

endpackage

// File: rtl/mod12_counter_sequencer_if.sv
// Request/response channel between the requesters and the sequencer.
interface mod12_counter_sequencer_if #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [2*NREQ-1:0] req_op;
    logic [4*NREQ-1:0] req_arg;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [3:0]        rsp_value;
    logic [1:0]        rsp_wraps;
    logic              rsp_err;

    modport master (
        output req_valid, req_op, req_arg, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_value, rsp_wraps, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_arg, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_value, rsp_wraps, rsp_err
    );
endinterface

// File: rtl/mod12_counter_sequencer_rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or after the pointer.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    input  logic            en_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  grant_idx_o,
    output logic            accept_o
);
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           found;
    int             k_idx;

    // Search NREQ positions starting at the pointer, wrapping modulo NREQ.
    always_comb begin
        found       = 1'b0;
        grant_idx_o = '0;
        k_idx       = 0;
        for (int i = 0; i < NREQ; i++) begin
            k_idx = int'(ptr_q) + i;
            if (k_idx >= NREQ) k_idx = k_idx - NREQ;
            if (!found && req_i[k_idx]) begin
                found       = 1'b1;
                grant_idx_o = IDW'(k_idx);
            end
        end
        accept_o = en_i && found;
        grant_o  = accept_o ? (NREQ'(1) << grant_idx_o) : '0;
        ptr_d    = ptr_q;
        if (accept_o) begin
            ptr_d = (int'(grant_idx_o) + 1 >= NREQ) ? '0 : grant_idx_o + IDW'(1);
        end
    end

    // Pointer advances past the winner only when a command is actually taken.
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
endmodule

// File: rtl/mod12_counter_sequencer.sv
// Sequencer sharing one external mod-12 up/down counter between NREQ requesters.
//
// state | meaning
// IDLE  | counter held by self-reload; arbiter may accept one command
// LOAD  | drive counter load with the accepted argument for one cycle
// STEP  | let the counter run n cycles in the requested direction
// RESP  | counter held; response presented until rsp_ready
module mod12_counter_sequencer #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    mod12_counter_sequencer_if.slave   bus,
    output logic                       cnt_load,
    output logic                       cnt_mode,
    output logic [3:0]                 cnt_datain,
    input  logic [3:0]                 cnt_dataout
);
    import mod12_seq_pkg::*;

    state_e         state_q, state_d;
    op_e            op_q, op_d;
    logic [3:0]     arg_q, arg_d;
    logic [3:0]     steps_q, steps_d;
    logic [1:0]     wraps_q, wraps_d;
    logic           err_q, err_d;
    logic [IDW-1:0] id_q, id_d;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            accept;
    logic            arb_en;
    op_e             sel_op;
    logic [3:0]      sel_arg;

    assign arb_en = (state_q == ST_IDLE) && !rst;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_i       (bus.req_valid),
        .en_i        (arb_en),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .accept_o    (accept)
    );

    assign bus.req_ready = grant;
    assign sel_op        = op_e'(bus.req_op[int'(grant_idx)*2 +: 2]);
    assign sel_arg       = bus.req_arg[int'(grant_idx)*4 +: 4];

    // Next-state: capture the granted command, run the step timer, track wraps.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        arg_d   = arg_q;
        steps_d = steps_q;
        wraps_d = wraps_q;
        err_d   = err_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    id_d    = grant_idx;
                    op_d    = sel_op;
                    arg_d   = sel_arg;
                    steps_d = sel_arg;
                    wraps_d = 2'd0;
                    err_d   = 1'b0;
                    case (sel_op)
                        OP_LOAD: begin
                            if (sel_arg > MOD_MAX) begin
                                err_d   = 1'b1;
                                state_d = ST_RESP;
                            end else begin
                                state_d = ST_LOAD;
                            end
                        end
                        OP_STEP_UP, OP_STEP_DOWN: begin
                            state_d = (sel_arg == 4'd0) ? ST_RESP : ST_STEP;
                        end
                        default: state_d = ST_RESP;
                    endcase
                end
            end
            ST_LOAD: state_d = ST_RESP;
            ST_STEP: begin
                if ((op_q == OP_STEP_UP && cnt_dataout == MOD_MAX) ||
                    (op_q == OP_STEP_DOWN && cnt_dataout == 4'd0)) begin
                    wraps_d = sat_inc2(wraps_q);
                end
                steps_d = steps_q - 4'd1;
                if (steps_q == 4'd1) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: counter control and response fields, all forced low during reset.
    always_comb begin
        cnt_load      = 1'b0;
        cnt_mode      = 1'b0;
        cnt_datain    = 4'd0;
        bus.rsp_valid = 1'b0;
        bus.rsp_id    = '0;
        bus.rsp_value = 4'd0;
        bus.rsp_wraps = 2'd0;
        bus.rsp_err   = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_LOAD: begin
                    cnt_load   = 1'b1;
                    cnt_datain = arg_q;
                end
                ST_STEP: begin
                    cnt_mode = (op_q == OP_STEP_UP);
                end
                ST_RESP: begin
                    cnt_load      = 1'b1;
                    cnt_datain    = cnt_dataout;
                    bus.rsp_valid = 1'b1;
                    bus.rsp_id    = id_q;
                    bus.rsp_value = cnt_dataout;
                    bus.rsp_wraps = wraps_q;
                    bus.rsp_err   = err_q;
                end
                default: begin
                    cnt_load   = 1'b1;
                    cnt_datain = cnt_dataout;
                end
            endcase
        end
    end

    // State and command registers; reset drops any in-flight command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LOAD;
            arg_q   <= 4'd0;
            steps_q <= 4'd0;
            wraps_q <= 2'd0;
            err_q   <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            arg_q   <= arg_d;
            steps_q <= steps_d;
            wraps_q <= wraps_d;
            err_q   <= err_d;
            id_q    <= id_d;
        end
    end
endmodule

// File: tb/tb_mod12_counter_sequencer.sv
// Bench for mod12_counter_sequencer with an external mod-12 counter model.
module tb_mod12_counter_sequencer;
    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       cnt_load, cnt_mode;
    logic [3:0] cnt_datain, cnt_dataout;
    logic [3:0] cnt_q;

    mod12_counter_sequencer_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    mod12_counter_sequencer #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .cnt_load    (cnt_load),
        .cnt_mode    (cnt_mode),
        .cnt_datain  (cnt_datain),
        .cnt_dataout (cnt_dataout)
    );

    always #5 clk = ~clk;

    // The shared counter: counts every clock unless loaded.
    always @(posedge clk) begin
        if (rst)           cnt_q <= 4'd0;
        else if (cnt_load) cnt_q <= cnt_datain;
        else if (cnt_mode) cnt_q <= (cnt_q == 4'd11) ? 4'd0 : cnt_q + 4'd1;
        else               cnt_q <= (cnt_q == 4'd0) ? 4'd11 : cnt_q - 4'd1;
    end
    assign cnt_dataout = cnt_q;

    int n_checks = 0;
    int n_errors = 0;
    int cur = 0;
    int ptr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: result of one command from the counter value v, by arithmetic.
    function automatic void model(input int op, input int arg, input int v,
                                  output int val, output int wr, output int err, output int lat);
        val = v; wr = 0; err = 0; lat = 1;
        case (op)
            0: begin
                if (arg > 11) err = 1;
                else begin val = arg; lat = 2; end
            end
            1: begin
                val = (v + arg) % 12;
                wr  = (v + arg) / 12;
                lat = (arg == 0) ? 1 : arg + 1;
            end
            2: begin
                val = (((v - arg) % 12) + 12) % 12;
                wr  = (arg > v) ? (arg - 1 - v) / 12 + 1 : 0;
                lat = (arg == 0) ? 1 : arg + 1;
            end
            default: ;
        endcase
        if (wr > 3) wr = 3;
    endfunction

    task automatic do_cmd(input int id, input int op, input int arg, input int hold);
        int val, wr, err, lat, lat_obs;
        bit got;
        logic [31:0] s_id, s_val, s_wr, s_err;
        model(op, arg, cur, val, wr, err, lat);
        @(negedge clk);
        bus.req_valid = '0;
        bus.req_valid[id] = 1'b1;
        bus.req_op[id*2 +: 2]  = 2'(op);
        bus.req_arg[id*4 +: 4] = 4'(arg);
        bus.rsp_ready = (hold == 0);
        #1;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.req_ready[id]) begin got = 1; break; end
            @(negedge clk); #1;
        end
        chk("grant_seen", 32'(got), 1);
        chk("grant_onehot", 32'(bus.req_ready), 32'd1 << id);
        ptr = (id + 1) % NREQ;
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        got = 0;
        lat_obs = 99;
        for (int k = 1; k <= 40; k++) begin
            if (bus.rsp_valid) begin got = 1; lat_obs = k; break; end
            if (op == 1 || op == 2) begin
                chk("step_load", 32'(cnt_load), 0);
                chk("step_mode", 32'(cnt_mode), (op == 1) ? 1 : 0);
            end
            if (op == 0 && k == 1) begin
                chk("load_strobe", 32'(cnt_load), 1);
                chk("load_datain", 32'(cnt_datain), arg);
            end
            @(negedge clk); #1;
        end
        chk("rsp_latency", lat_obs, lat);
        chk("rsp_id", 32'(bus.rsp_id), id);
        chk("rsp_value", 32'(bus.rsp_value), val);
        chk("rsp_wraps", 32'(bus.rsp_wraps), wr);
        chk("rsp_err", 32'(bus.rsp_err), err);
        if (hold > 0) begin
            s_id = 32'(bus.rsp_id); s_val = 32'(bus.rsp_value);
            s_wr = 32'(bus.rsp_wraps); s_err = 32'(bus.rsp_err);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                bus.req_valid = '1;
                bus.req_op = '1;
                #1;
                chk("hold_valid", 32'(bus.rsp_valid), 1);
                chk("hold_id", 32'(bus.rsp_id), s_id);
                chk("hold_value", 32'(bus.rsp_value), s_val);
                chk("hold_wraps", 32'(bus.rsp_wraps), s_wr);
                chk("hold_err", 32'(bus.rsp_err), s_err);
                chk("hold_no_ready", 32'(bus.req_ready), 0);
                chk("hold_counter", 32'(cnt_dataout), val);
            end
            bus.req_valid = '0;
            bus.rsp_ready = 1'b1;
        end
        @(negedge clk); #1;
        chk("rsp_dropped", 32'(bus.rsp_valid), 0);
        chk("counter_after", 32'(cnt_dataout), val);
        cur = val;
    endtask

    task automatic rr_run(input int n);
        int exp_id;
        @(negedge clk);
        bus.req_valid = '1;
        bus.req_op    = '1;
        bus.rsp_ready = 1'b1;
        #1;
        for (int r = 0; r < n; r++) begin
            chk("rr_grant", 32'(bus.req_ready), 32'd1 << ptr);
            exp_id = ptr;
            ptr = (ptr + 1) % NREQ;
            @(negedge clk); #1;
            chk("rr_rsp_valid", 32'(bus.rsp_valid), 1);
            chk("rr_rsp_id", 32'(bus.rsp_id), exp_id);
            chk("rr_rsp_value", 32'(bus.rsp_value), cur);
            @(negedge clk); #1;
        end
        bus.req_valid = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.req_valid = '1;
        bus.req_op    = '0;
        bus.req_arg   = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) begin
            @(negedge clk); #1;
            chk("rst_ready", 32'(bus.req_ready), 0);
            chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
            chk("rst_cnt_load", 32'(cnt_load), 0);
            chk("rst_cnt_mode", 32'(cnt_mode), 0);
            chk("rst_cnt_datain", 32'(cnt_datain), 0);
        end
        rst = 1'b0;
        bus.req_valid = '0;
        repeat (10) begin
            @(negedge clk); #1;
            chk("idle_counter", 32'(cnt_dataout), 0);
            chk("idle_load", 32'(cnt_load), 1);
            chk("idle_ready", 32'(bus.req_ready), 0);
        end

        do_cmd(0, 0, 9, 0);
        do_cmd(0, 1, 5, 0);
        do_cmd(1, 0, 0, 0);
        do_cmd(1, 2, 15, 0);
        do_cmd(1, 0, 12, 0);
        do_cmd(0, 3, 0, 0);

        rr_run(4);

        do_cmd(1, 1, 3, 8);

        // Reset in the middle of a long step.
        @(negedge clk);
        bus.req_valid = 2'b01;
        bus.req_op[1:0]  = 2'd1;
        bus.req_arg[3:0] = 4'd10;
        bus.rsp_ready = 1'b1;
        #1;
        chk("midrst_grant", 32'(bus.req_ready), 1);
        @(negedge clk);
        bus.req_valid = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bus.req_valid = '1;
        @(negedge clk); #1;
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("midrst_ready", 32'(bus.req_ready), 0);
        chk("midrst_counter", 32'(cnt_dataout), 0);
        rst = 1'b0;
        bus.req_valid = '0;
        #1;
        chk("midrst_idle_load", 32'(cnt_load), 1);
        cur = 0;
        ptr = 0;
        rr_run(2);
        do_cmd(1, 0, 7, 0);
        do_cmd(0, 2, 8, 0);

        for (int i = 0; i < 40; i++) begin
            do_cmd($urandom_range(0, NREQ - 1), $urandom_range(0, 3),
                   $urandom_range(0, 15), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
